// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for restoring_divider.
//   state_t        - FSM state encoding (IDLE, CALC, DONE)
//   DEFAULT_WIDTH  - default operand / quotient / remainder width
//   DEFAULT_CNT_W  - iteration counter width for DEFAULT_WIDTH
//   cnt_width()    - iteration counter width for an arbitrary WIDTH
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// restoring_divider_if: start/busy/done handshake and operand/result bus.
//   master: drives start, dividend, divisor; observes results
//   slave : the divider side
//   start       - request strobe, sampled only while the divider is idle
//   dividend    - numerator, latched on an accepted start
//   divisor     - denominator, latched on an accepted start
//   busy        - high during the iteration cycles
//   done        - one-cycle pulse, results valid on and after it
//   quotient    - floor(dividend / divisor)
//   remainder   - dividend mod divisor
//   div_by_zero - flags a zero divisor, updated with done
interface restoring_divider_if
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_borrow_subtractor.sv
// borrow_subtractor: WIDTH-bit ripple-borrow subtractor, diff = a - b.
//   a          - minuend
//   b          - subtrahend
//   diff       - a - b modulo 2**WIDTH
//   borrow_out - 1 when b > a
module borrow_subtractor #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    logic [WIDTH:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        // Borrow out of this bit: b alone exceeds a, or the two are equal
        // and a borrow is already coming in from below.
        assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign borrow_out = borrow[WIDTH];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned restoring divider, one quotient
// bit per clock, WIDTH iterations per operation.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - restoring_divider_if.slave (start/busy/done handshake, operands,
//           quotient, remainder, div_by_zero)
// Build option: DIVIDER_ZERO_BYPASS_EN - a zero divisor skips the iteration
// phase and completes one cycle after start. Without it a zero divisor runs
// all WIDTH iterations and yields the same result values.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// CALC  | one trial subtraction per cycle, counter running down
// DONE  | results presented, done pulse high for this cycle
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    restoring_divider_if.slave   bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH:0]     r;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   dvs;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     r_shift;
    logic [WIDTH:0]     diff;
    logic               borrow;
    logic [WIDTH:0]     r_next;
    logic [WIDTH-1:0]   q_next;

    assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};

    borrow_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
        .a          (r_shift),
        .b          ({1'b0, dvs}),
        .diff       (diff),
        .borrow_out (borrow)
    );

    // Restore on borrow: keep the shifted remainder, quotient bit 0.
    assign r_next = borrow ? r_shift : diff;
    assign q_next = {q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            r               <= '0;
            q               <= '0;
            dvs             <= '0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        dvs <= bus.divisor;
                        r   <= '0;
                        q   <= bus.dividend;
                        cnt <= CNT_W'(WIDTH);
`ifdef DIVIDER_ZERO_BYPASS_EN
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state    <= CALC;
                            bus.busy <= 1'b1;
                        end
`else
                        state    <= CALC;
                        bus.busy <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - CNT_W'(1);
                    // Results are captured on the way into DONE so they are
                    // already valid in the cycle done is high.
                    if (cnt == CNT_W'(1)) begin
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.quotient    <= q_next;
                        bus.remainder   <= r_next[WIDTH-1:0];
                        bus.div_by_zero <= (dvs == '0);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

    // A restored partial remainder is always below the divisor, so the
    // extra top bit of R never gets set.
    a_r_top_clear: assert property (@(posedge clk) disable iff (!rst_n)
        r[WIDTH] == 1'b0);

endmodule
